// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and sizes, used by stopwatch_timer and its lap FIFO.
package stopwatch_pkg;

  localparam int unsigned COUNT_W   = 16;
  localparam int unsigned LAP_DEPTH = 4;

  typedef logic [COUNT_W-1:0] sw_count_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector. The history register resets high, so a level that is
// already high when reset releases is not reported as an edge.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic r_sig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sig_q <= 1'b1;
    end else begin
      r_sig_q <= sig;
    end
  end

  assign rise = sig & ~r_sig_q;

endmodule

// File: rtl/stopwatch_lap_fifo.sv
// Lap snapshot queue: captures the stopwatch count on each lap rising edge and
// presents the snapshots first-word-fall-through on a valid/ready port.
module stopwatch_lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W,
  parameter int unsigned DEPTH = LAP_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count,
  input  logic                     lap,
  input  logic                     clear,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LvlW-1:0]  r_level, w_level_nxt;
  logic             r_overflow;
  logic             w_lap_rise, w_full, w_pop, w_push, w_drop;

  rise_edge_detect u_lap_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (lap),
    .rise  (w_lap_rise)
  );

  assign w_full = (r_level == LvlW'(DEPTH));
  assign w_pop  = out_valid & out_ready;
  // A full queue still accepts a lap when the head leaves in the same cycle.
  assign w_push = w_lap_rise & (~w_full | w_pop);
  assign w_drop = w_lap_rise & w_full & ~w_pop;

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LvlW'(1);
      2'b01:   w_level_nxt = r_level - LvlW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_drop) r_overflow <= 1'b1;
      r_level <= w_level_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= count;
  end

  assign out_valid = (r_level != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_stopwatch_lap_fifo.sv
// Directed bench for stopwatch_lap_fifo: lap capture, ordering, overflow,
// full-with-pop and clear priority, with hand-computed expectations.
module tb_stopwatch_lap_fifo;
  import stopwatch_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  sw_count_t  count;
  logic       lap, clear, out_ready;
  sw_count_t  out_data;
  logic       out_valid, overflow;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_lap_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .lap       (lap),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lap_pulse(input int v);
    count = 16'(v);
    lap   = 1'b1;
    step();
    lap   = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; lap = 1'b1; count = '0; clear = 1'b0; out_ready = 1'b0;
    step(); step();
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      count = 16'(100 + i);
      step();
    end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL held_lap_level got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL held_lap_valid got %b want 0", out_valid); end
    lap = 1'b0;
    step();
    lap_pulse(3);
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL first_lap_level got %0d want 1", level); end
    n_checks++; if (out_data !== 16'd3) begin n_fail++; $display("FAIL first_lap_data got %0d want 3", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    lap_pulse(5); lap_pulse(9); lap_pulse(12);
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL basic_level got %0d want 3", level); end
    out_ready = 1'b1;
    n_checks++; if (out_data !== 16'd5) begin n_fail++; $display("FAIL basic_d0 got %0d want 5", out_data); end
    step();
    n_checks++; if (out_data !== 16'd9) begin n_fail++; $display("FAIL basic_d1 got %0d want 9", out_data); end
    n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL basic_lvl2 got %0d want 2", level); end
    step();
    n_checks++; if (out_data !== 16'd12) begin n_fail++; $display("FAIL basic_d2 got %0d want 12", out_data); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty_valid got %b want 0", out_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL basic_empty_level got %0d want 0", level); end
    // out_ready while empty must not disturb anything.
    step();
    out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL empty_pop_level got %0d want 0", level); end
  endtask

  task automatic test_hold();
    lap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      count = 16'(20 + i);
      step();
    end
    lap = 1'b0;
    step();
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL hold_level got %0d want 1", level); end
    n_checks++; if (out_data !== 16'd20) begin n_fail++; $display("FAIL hold_data got %0d want 20", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL hold_drain got %0d want 0", level); end
  endtask

  task automatic test_overflow();
    lap_pulse(31); lap_pulse(32); lap_pulse(33); lap_pulse(34);
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_full got %0d want 4", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow); end
    lap_pulse(40);
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data !== 16'(31 + i)) begin
        n_fail++; $display("FAIL ovf_drain%0d got %0d want %0d", i, out_data, 31 + i);
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", out_valid); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    int exp_q[5] = '{41, 42, 43, 44, 50};
    lap_pulse(41); lap_pulse(42); lap_pulse(43); lap_pulse(44);
    count = 16'd50; lap = 1'b1; out_ready = 1'b1;
    n_checks++; if (out_data !== 16'd41) begin n_fail++; $display("FAIL fp_head got %0d want 41", out_data); end
    step();
    lap = 1'b0;
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fp_level got %0d want 4", level); end
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (out_data !== 16'(exp_q[i])) begin
        n_fail++; $display("FAIL fp_drain%0d got %0d want %0d", i, out_data, exp_q[i]);
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL fp_empty got %0d want 0", level); end
  endtask

  task automatic test_clear();
    lap_pulse(61); lap_pulse(62); lap_pulse(63);
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL clr_pre_level got %0d want 3", level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre_ovf got %b want 1", overflow); end
    clear = 1'b1; count = 16'd70; lap = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; lap = 1'b0; out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL clr_level got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %b want 0", out_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", overflow); end
    step();
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL clr_no_entry got %0d want 0", level); end
    count = 16'd77; lap = 1'b1;
    step();
    lap = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL post_clr_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== 16'd77) begin n_fail++; $display("FAIL post_clr_data got %0d want 77", out_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_full_pop();
    test_clear();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
